// File: rtl/gpr_wb_ctrl.sv
// Write-back controller: buffers one ALU and one load result, arbitrates them onto
// the single GPR write port and keeps a per-register pending count for hazard checks.
module gpr_wb_ctrl #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              we_,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr_0,
  output logic              chk_busy_0,
  input  logic [ADDR_W-1:0] chk_addr_1,
  output logic              chk_busy_1
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [1:0]       STARVE_LIM = 2'd2;

  logic [CNT_W-1:0]  r_cnt [REG_NUM];
  logic              r_alu_vld;
  logic [ADDR_W-1:0] r_alu_addr;
  logic [DATA_W-1:0] r_alu_data;
  logic              r_mem_vld;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic [1:0]        r_starve;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_gnt_alu;
  logic              w_gnt_mem;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [CNT_W-1:0]  w_iss_cnt;
  logic              w_iss_fire;
  logic [REG_NUM-1:0] w_inc;
  logic [REG_NUM-1:0] w_dec;
  logic [ADDR_W-1:0] w_chk_addr [2];
  logic [CNT_W-1:0]  w_chk_cnt [2];
  logic [1:0]        w_busy;

  // MEM wins by default; ALU takes the conflict once MEM has won twice over it.
  assign w_gnt_alu  = r_alu_vld && (!r_mem_vld || r_starve == STARVE_LIM);
  assign w_gnt_mem  = r_mem_vld && !w_gnt_alu;
  assign w_sel_addr = w_gnt_mem ? r_mem_addr : r_alu_addr;
  assign w_sel_data = w_gnt_mem ? r_mem_data : r_alu_data;

  assign alu_ready = !reset && (!r_alu_vld || w_gnt_alu);
  assign mem_ready = !reset && (!r_mem_vld || w_gnt_mem);

  assign w_iss_cnt  = r_cnt[iss_addr];
  assign iss_ready  = !reset && (w_iss_cnt != CNT_MAX);
  assign w_iss_fire = iss_valid && iss_ready && (iss_addr != '0);

  assign we_     = r_we_n;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_upd
      assign w_inc[gi] = w_iss_fire && (iss_addr == ADDR_W'(gi));
      assign w_dec[gi] = !r_we_n && (r_wr_addr == ADDR_W'(gi));
    end
  endgenerate

  assign w_chk_addr[0] = chk_addr_0;
  assign w_chk_addr[1] = chk_addr_1;

  // A count of one being written this cycle is visible through the write-through bypass.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chk
      assign w_chk_cnt[gi] = r_cnt[w_chk_addr[gi]];
      assign w_busy[gi] = (w_chk_addr[gi] != '0) && (w_chk_cnt[gi] != '0) &&
                          !(!r_we_n && (r_wr_addr == w_chk_addr[gi]) &&
                            (w_chk_cnt[gi] == CNT_W'(1)));
    end
  endgenerate

  assign chk_busy_0 = w_busy[0];
  assign chk_busy_1 = w_busy[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_vld  <= 1'b0;
      r_alu_addr <= '0;
      r_alu_data <= '0;
      r_mem_vld  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_starve   <= '0;
      r_we_n     <= 1'b1;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      if (alu_valid && alu_ready) begin
        r_alu_vld  <= 1'b1;
        r_alu_addr <= alu_addr;
        r_alu_data <= alu_data;
      end else if (w_gnt_alu) begin
        r_alu_vld <= 1'b0;
      end

      if (mem_valid && mem_ready) begin
        r_mem_vld  <= 1'b1;
        r_mem_addr <= mem_addr;
        r_mem_data <= mem_data;
      end else if (w_gnt_mem) begin
        r_mem_vld <= 1'b0;
      end

      // Writes to r0 are dropped but leave the last address/data on the port.
      if ((w_gnt_alu || w_gnt_mem) && w_sel_addr != '0) begin
        r_we_n    <= 1'b0;
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end else begin
        r_we_n <= 1'b1;
      end

      if (w_gnt_alu)
        r_starve <= '0;
      else if (w_gnt_mem && r_alu_vld && r_starve != 2'd3)
        r_starve <= r_starve + 2'd1;
    end
  end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed vector table, corner-case sequences and a
// randomized run against a cycle-level reference model.
module tb_gpr_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, alu_valid, mem_valid;
  logic [4:0]  iss_addr, alu_addr, mem_addr, chk_addr_0, chk_addr_1;
  logic [31:0] alu_data, mem_data;
  logic        iss_ready, alu_ready, mem_ready, we_, chk_busy_0, chk_busy_1;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  gpr_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_addr_0(chk_addr_0), .chk_busy_0(chk_busy_0),
    .chk_addr_1(chk_addr_1), .chk_busy_1(chk_busy_1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cnt [32];
  bit          m_ah_v, m_mh_v;
  int          m_ah_a, m_mh_a;
  logic [31:0] m_ah_d, m_mh_d;
  int          m_starve;
  bit          m_we_n;
  int          m_wa;
  logic [31:0] m_wd;
  int          m_win;
  bit          e_iss_rdy, e_alu_rdy, e_mem_rdy, e_b0, e_b1;
  int          wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int a);
    return a != 0 && m_cnt[a] > 0 && !(!m_we_n && m_wa == a && m_cnt[a] == 1);
  endfunction

  task automatic model_comb();
    if (m_ah_v && m_mh_v) m_win = (m_starve >= 2) ? 1 : 2;
    else if (m_mh_v)      m_win = 2;
    else if (m_ah_v)      m_win = 1;
    else                  m_win = 0;
    e_iss_rdy = !reset && m_cnt[int'(iss_addr)] < 3;
    e_alu_rdy = !reset && (!m_ah_v || m_win == 1);
    e_mem_rdy = !reset && (!m_mh_v || m_win == 2);
    e_b0 = m_busy(int'(chk_addr_0));
    e_b1 = m_busy(int'(chk_addr_1));
  endtask

  task automatic model_update();
    int inc_a, dec_a;
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ah_v = 0; m_mh_v = 0; m_starve = 0;
      m_we_n = 1; m_wa = 0; m_wd = '0;
      return;
    end
    inc_a = (iss_valid && e_iss_rdy && iss_addr != 0) ? int'(iss_addr) : -1;
    dec_a = m_we_n ? -1 : m_wa;
    if (inc_a >= 0 && inc_a != dec_a) m_cnt[inc_a]++;
    if (dec_a >= 0 && dec_a != inc_a && m_cnt[dec_a] > 0) m_cnt[dec_a]--;
    m_we_n = 1;
    if (m_win == 1) begin
      if (m_ah_a != 0) begin m_we_n = 0; m_wa = m_ah_a; m_wd = m_ah_d; end
      m_ah_v = 0;
      m_starve = 0;
    end else if (m_win == 2) begin
      if (m_mh_a != 0) begin m_we_n = 0; m_wa = m_mh_a; m_wd = m_mh_d; end
      m_mh_v = 0;
      if (m_ah_v) m_starve++;
    end
    if (alu_valid && e_alu_rdy) begin m_ah_v = 1; m_ah_a = int'(alu_addr); m_ah_d = alu_data; end
    if (mem_valid && e_mem_rdy) begin m_mh_v = 1; m_mh_a = int'(mem_addr); m_mh_d = mem_data; end
  endtask

  task automatic sample();
    #1;
    model_comb();
    if (we_ === 1'b0) wq.push_back(int'(wr_addr));
  endtask

  task automatic check_model();
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, e_iss_rdy});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_alu_rdy});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_mem_rdy});
    chk("we_", {31'd0, we_}, {31'd0, m_we_n});
    chk("wr_addr", {27'd0, wr_addr}, 32'(m_wa));
    chk("wr_data", wr_data, m_wd);
    chk("chk_busy_0", {31'd0, chk_busy_0}, {31'd0, e_b0});
    chk("chk_busy_1", {31'd0, chk_busy_1}, {31'd0, e_b1});
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    check_model();
    advance();
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_addr = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  typedef struct {
    bit rst; bit iv; int ia; bit av; int aa; int ad; bit mv; int ma; int md; int c0; int c1;
    bit e_ir; bit e_ar; bit e_mr; bit e_we; int e_wa; int e_wd; bit e_b0; bit e_b1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // rst iv ia av aa ad       mv ma md   c0 c1 | ir ar mr we wa wd      b0 b1
    tbl[0]  = '{1, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  0, 0, 0, 1, 0, 0,      0, 0};
    tbl[1]  = '{0, 1, 5, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 1, 0, 0,      0, 0};
    tbl[2]  = '{0, 0, 0, 1, 5, 'h1234, 0, 0, 0,   5, 3,  1, 1, 1, 1, 0, 0,      1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 1, 0, 0,      1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 0, 5, 'h1234, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0,      0, 0, 0,   0, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 'hFFFF, 0, 0, 0,   0, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   0, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   0, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[10] = '{0, 1, 3, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 1, 5, 'h1234, 0, 0};
    tbl[11] = '{0, 1, 4, 1, 3, 'hA,    1, 4, 'hB, 5, 3,  1, 1, 1, 1, 5, 'h1234, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 0, 1, 1, 5, 'h1234, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 0, 4, 'hB,    0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 0, 3, 'hA,    0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,   5, 3,  1, 1, 1, 1, 3, 'hA,    0, 0};

    reset = 1; idle_inputs(); chk_addr_0 = 0; chk_addr_1 = 0;
    @(negedge clk);
    repeat (2) begin sample(); advance(); end

    // Directed vectors: ALU latency, r0 handling, simultaneous results
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst;
      iss_valid = tbl[i].iv; iss_addr = 5'(tbl[i].ia);
      alu_valid = tbl[i].av; alu_addr = 5'(tbl[i].aa); alu_data = 32'(tbl[i].ad);
      mem_valid = tbl[i].mv; mem_addr = 5'(tbl[i].ma); mem_data = 32'(tbl[i].md);
      chk_addr_0 = 5'(tbl[i].c0); chk_addr_1 = 5'(tbl[i].c1);
      sample();
      $display("vec %0d: we_=%b wr_addr=%0d wr_data=0x%0h readys=%b%b%b busy=%b%b",
               i, we_, wr_addr, wr_data, iss_ready, alu_ready, mem_ready, chk_busy_0, chk_busy_1);
      chk("vec_iss_ready", {31'd0, iss_ready}, {31'd0, tbl[i].e_ir});
      chk("vec_alu_ready", {31'd0, alu_ready}, {31'd0, tbl[i].e_ar});
      chk("vec_mem_ready", {31'd0, mem_ready}, {31'd0, tbl[i].e_mr});
      chk("vec_we_", {31'd0, we_}, {31'd0, tbl[i].e_we});
      chk("vec_wr_addr", {27'd0, wr_addr}, 32'(tbl[i].e_wa));
      chk("vec_wr_data", wr_data, 32'(tbl[i].e_wd));
      chk("vec_busy_0", {31'd0, chk_busy_0}, {31'd0, tbl[i].e_b0});
      chk("vec_busy_1", {31'd0, chk_busy_1}, {31'd0, tbl[i].e_b1});
      advance();
    end
    idle_inputs();

    // Starvation guard: ALU r7 waits behind two MEM results
    wq.delete();
    chk_addr_0 = 7; chk_addr_1 = 8;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    mem_valid = 1; mem_addr = 8; mem_data = 32'h88;
    cyc();
    alu_valid = 0;
    mem_addr = 9; mem_data = 32'h99;
    cyc();
    mem_addr = 10; mem_data = 32'hAA;
    cyc();
    mem_valid = 0;
    repeat (4) cyc();
    chk("starve_count", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      chk("starve_w0", 32'(wq[0]), 32'd8);
      chk("starve_w1", 32'(wq[1]), 32'd9);
      chk("starve_w2", 32'(wq[2]), 32'd7);
      chk("starve_w3", 32'(wq[3]), 32'd10);
    end

    // Scoreboard saturation and same-edge increment/decrement on r6
    chk_addr_0 = 6;
    iss_valid = 1; iss_addr = 6;
    repeat (3) cyc();
    alu_valid = 1; alu_addr = 6; alu_data = 32'h61;
    sample(); chk("sat_stall", {31'd0, iss_ready}, 32'd0); check_model(); advance();
    alu_data = 32'h62;
    cyc();
    alu_valid = 0;
    sample(); chk("sat_stall_on_write", {31'd0, iss_ready}, 32'd0); check_model(); advance();
    sample(); chk("sat_release", {31'd0, iss_ready}, 32'd1); check_model(); advance();
    sample(); chk("same_edge_unchanged", {31'd0, iss_ready}, 32'd1); check_model(); advance();
    iss_valid = 0;
    repeat (2) cyc();

    // Reset with a MEM result held
    chk_addr_0 = 6; chk_addr_1 = 9;
    mem_valid = 1; mem_addr = 9; mem_data = 32'h999;
    cyc();
    mem_valid = 0;
    reset = 1;
    sample();
    chk("rst_readys", {29'd0, iss_ready, alu_ready, mem_ready}, 32'd0);
    check_model();
    advance();
    reset = 0;
    sample();
    chk("rst_we_", {31'd0, we_}, 32'd1);
    chk("rst_busy", {30'd0, chk_busy_0, chk_busy_1}, 32'd0);
    check_model();
    advance();
    repeat (3) begin
      sample(); chk("rst_no_stale", {31'd0, we_}, 32'd1); check_model(); advance();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit ihs, ahs, mhs;
      if (!iss_valid && $urandom_range(2) == 0) begin iss_valid = 1; iss_addr = 5'($urandom_range(7)); end
      if (!alu_valid && $urandom_range(2) == 0) begin
        alu_valid = 1; alu_addr = 5'($urandom_range(7)); alu_data = $urandom;
      end
      if (!mem_valid && $urandom_range(2) == 0) begin
        mem_valid = 1; mem_addr = 5'($urandom_range(7)); mem_data = $urandom;
      end
      chk_addr_0 = 5'($urandom_range(7));
      chk_addr_1 = 5'($urandom_range(7));
      reset = ($urandom_range(199) == 0);
      sample();
      check_model();
      ihs = iss_valid && e_iss_rdy;
      ahs = alu_valid && e_alu_rdy;
      mhs = mem_valid && e_mem_rdy;
      advance();
      if (ihs) iss_valid = 0;
      if (ahs) alu_valid = 0;
      if (mhs) mem_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
